// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV64 datapath, with memory timeout and retire count.
// Optional build macro MC_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT instead of retiring as NOPs.
module multicycle_control #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [6:0]  opcode_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        alu_src_o,
    output logic        mem_to_reg_o,
    output logic [1:0]  alu_op_o,
    output logic [2:0]  state_o,
    output logic [63:0] instret_o,
    output logic        bus_err_o,
    output logic        illegal_o
);
    // state     | meaning
    // S_FETCH   | request instruction, wait for imem_ready
    // S_DECODE  | latch opcode
    // S_EXECUTE | ALU setup, branch resolve
    // S_MEM     | load/store, wait for dmem_ready
    // S_WB      | register file write, retire
    // S_HALT    | bus timeout or trapped opcode, left only by reset
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [7:0]  wait_q, wait_d;
    logic [63:0] instret_q;
    logic        bus_err_q, bus_err_d;
    logic        illegal_q, illegal_d;
    logic        retire;

    logic is_r, is_i, is_ld, is_st, is_br;
    assign is_r  = (op_q == OP_R);
    assign is_i  = (op_q == OP_I);
    assign is_ld = (op_q == OP_LOAD);
    assign is_st = (op_q == OP_STORE);
    assign is_br = (op_q == OP_BRANCH);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            instret_q <= instret_q + 64'(retire);
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    // The wait counter only survives while stalled in FETCH or MEM, so every entry starts from zero.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = '0;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready_i) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                op_d    = opcode_i;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_r || is_i) begin
                    state_d = S_WB;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d = S_FETCH;
                    retire  = 1'b1;
`endif
                end
            end
            S_MEM: begin
                if (dmem_ready_i) begin
                    state_d = is_ld ? S_WB : S_FETCH;
                    retire  = !is_ld;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // FETCH outputs are held off while reset is asserted, since the state register already reads FETCH.
    always_comb begin
        imem_req_o      = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        reg_write_o     = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        alu_src_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_op_o        = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req_o = rst_n_i;
                ir_write_o = rst_n_i && imem_ready_i;
                pc_write_o = rst_n_i && imem_ready_i;
            end
            S_EXECUTE: begin
                if (is_r || is_i) begin
                    alu_op_o  = 2'b10;
                    alu_src_o = is_i;
                end else if (is_ld || is_st) begin
                    alu_src_o = 1'b1;
                end else if (is_br) begin
                    alu_op_o        = 2'b01;
                    pc_write_cond_o = 1'b1;
                end
            end
            S_MEM: begin
                mem_read_o  = is_ld;
                mem_write_o = is_st;
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = is_ld;
            end
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign instret_o = instret_q;
    assign bus_err_o = bus_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif
endmodule
